// File: rtl/dcr_pkg.sv
// Shared types and width helpers for the multi-channel DC-removal block.
package dcr_pkg;

  typedef enum logic {
    DCR_BLOCK = 1'b0,
    DCR_IIR   = 1'b1
  } dcr_mode_e;

  // The block-average sum and the IIR accumulator share one register per channel,
  // so it is sized for whichever of the two needs more headroom.
  function automatic int sum_w(input int data_w, input int log2_win, input int iir_shift);
    return data_w + ((log2_win > iir_shift) ? log2_win : iir_shift);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/dcr_chan_update.sv
// Combinational next-state and offset-corrected difference for one channel.
module dcr_chan_update
  import dcr_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LOG2_WIN   = 10,
  parameter int IIR_SHIFT  = 6,
  parameter int SUM_W      = sum_w(DATA_WIDTH, LOG2_WIN, IIR_SHIFT)
) (
  input  dcr_mode_e               mode,
  input  logic [DATA_WIDTH-1:0]   sample,
  input  logic [SUM_W-1:0]        acc,
  input  logic [LOG2_WIN-1:0]     cnt,
  input  logic [DATA_WIDTH-1:0]   avg,
  input  logic                    settled,
  output logic [SUM_W-1:0]        acc_n,
  output logic [LOG2_WIN-1:0]     cnt_n,
  output logic [DATA_WIDTH-1:0]   avg_n,
  output logic                    settled_n,
  output logic signed [DATA_WIDTH:0] diff
);

  localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;

  logic [SUM_W-1:0]      sample_ext;
  logic [SUM_W-1:0]      acc_plus;
  logic [SUM_W-1:0]      est_ext;
  logic [DATA_WIDTH-1:0] est;

  always_comb begin
    sample_ext = SUM_W'(sample);
    acc_plus   = acc + sample_ext;
    est        = DATA_WIDTH'(acc >> IIR_SHIFT);
    est_ext    = SUM_W'(est);
    acc_n      = acc;
    cnt_n      = cnt;
    avg_n      = avg;
    settled_n  = settled;
    diff       = '0;
    if (mode == DCR_BLOCK) begin
      diff = $signed({1'b0, sample}) - $signed({1'b0, avg});
      if (cnt == CNT_MAX) begin
        avg_n     = DATA_WIDTH'(acc_plus >> LOG2_WIN);
        acc_n     = '0;
        cnt_n     = '0;
        settled_n = 1'b1;
      end else begin
        acc_n = acc_plus;
        cnt_n = cnt + LOG2_WIN'(1);
      end
    end else begin
      diff = $signed({1'b0, sample}) - $signed({1'b0, est});
      // acc never exceeds 2^(DATA_WIDTH+IIR_SHIFT), so this cannot wrap.
      acc_n = acc_plus - est_ext;
      if (cnt != CNT_MAX) cnt_n = cnt + LOG2_WIN'(1);
      else                settled_n = 1'b1;
    end
  end

endmodule

// File: rtl/dc_removal_mc.sv
// Multi-channel DC removal (block average or IIR), 2-cycle latency.
// Optional output clamping with saturation flag when DCR_SAT_EN is defined.
module dc_removal_mc
  import dcr_pkg::*;
#(
  parameter int  DATA_WIDTH = 12,
  parameter int  NUM_CH     = 4,
  parameter int  LOG2_WIN   = 10,
  parameter int  IIR_SHIFT  = 6,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [DATA_WIDTH:0]   out_data,
  output logic                  out_settled,
  output logic                  out_sat
);

  localparam int SUM_W = sum_w(DATA_WIDTH, LOG2_WIN, IIR_SHIFT);

  typedef struct packed {
    logic [SUM_W-1:0]      acc;
    logic [LOG2_WIN-1:0]   cnt;
    logic [DATA_WIDTH-1:0] avg;
    logic                  settled;
  } chan_state_t;

  chan_state_t st [NUM_CH];
  chan_state_t cur;
  chan_state_t nxt;

  dcr_mode_e mode_in;
  dcr_mode_e mode_q;
  logic      flush_all;
  logic      ch_ok;
  logic      accept;
  logic [CH_W-1:0] rd_idx;

  logic signed [DATA_WIDTH:0] diff;
  logic                       s1_valid;
  logic [CH_W-1:0]            s1_ch;
  logic signed [DATA_WIDTH:0] s1_diff;
  logic                       s1_settled;
  logic signed [DATA_WIDTH:0] sat_data;

  if (NUM_CH == (1 << CH_W)) begin : g_pow2
    assign ch_ok = 1'b1;
  end else begin : g_npow2
    assign ch_ok = (32'(in_ch) < NUM_CH);
  end

  assign mode_in   = dcr_mode_e'(mode);
  // A change of operating mode invalidates every estimate, same as an explicit flush.
  assign flush_all = flush | (mode_in != mode_q);
  assign accept    = in_valid & ch_ok & ~flush_all;
  assign rd_idx    = ch_ok ? in_ch : '0;
  assign cur       = st[rd_idx];

  dcr_chan_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_WIN   (LOG2_WIN),
    .IIR_SHIFT  (IIR_SHIFT),
    .SUM_W      (SUM_W)
  ) u_chan_update (
    .mode      (mode_q),
    .sample    (in_data),
    .acc       (cur.acc),
    .cnt       (cur.cnt),
    .avg       (cur.avg),
    .settled   (cur.settled),
    .acc_n     (nxt.acc),
    .cnt_n     (nxt.cnt),
    .avg_n     (nxt.avg),
    .settled_n (nxt.settled),
    .diff      (diff)
  );

  always_ff @(posedge adc_clk) begin
    mode_q <= mode_in;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
      s1_valid    <= 1'b0;
      s1_ch       <= '0;
      s1_diff     <= '0;
      s1_settled  <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_data    <= '0;
      out_settled <= 1'b0;
    end else begin
      if (flush_all) begin
        for (int i = 0; i < NUM_CH; i++) st[i] <= '0;
      end else if (accept) begin
        st[rd_idx] <= nxt;
      end
      s1_valid    <= accept;
      s1_ch       <= in_ch;
      s1_diff     <= diff;
      s1_settled  <= cur.settled;
      out_valid   <= s1_valid;
      out_ch      <= s1_ch;
      out_data    <= sat_data;
      out_settled <= s1_settled;
    end
  end

`ifdef DCR_SAT_EN
  localparam logic signed [DATA_WIDTH:0] SAT_HI = $signed({2'b00, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [DATA_WIDTH:0] SAT_LO = $signed({2'b11, {(DATA_WIDTH-1){1'b0}}});

  logic sat_flag;

  always_comb begin
    sat_data = s1_diff;
    sat_flag = 1'b0;
    if (s1_diff > SAT_HI) begin
      sat_data = SAT_HI;
      sat_flag = 1'b1;
    end else if (s1_diff < SAT_LO) begin
      sat_data = SAT_LO;
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (rst) out_sat <= 1'b0;
    else     out_sat <= sat_flag & s1_valid;
  end
`else
  assign sat_data = s1_diff;
  assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_dc_removal_mc.sv
// Scoreboard bench for dc_removal_mc against a window/IIR arithmetic reference model.
module tb_dc_removal_mc;

  localparam int DW        = 12;
  localparam int NCH       = 4;
  localparam int LOG2_WIN  = 4;
  localparam int IIR_SHIFT = 4;
  localparam int WIN       = 1 << LOG2_WIN;

  logic          adc_clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_ch = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [1:0]    out_ch;
  logic [DW:0]   out_data;
  logic          out_settled;
  logic          out_sat;

  dc_removal_mc #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NCH),
    .LOG2_WIN   (LOG2_WIN),
    .IIR_SHIFT  (IIR_SHIFT)
  ) dut (
    .adc_clk     (adc_clk),
    .rst         (rst),
    .mode        (mode),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ch       (in_ch),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ch      (out_ch),
    .out_data    (out_data),
    .out_settled (out_settled),
    .out_sat     (out_sat)
  );

  always #5 adc_clk = ~adc_clk;

  int cyc = 0;
  always @(posedge adc_clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int data;
    bit settled;
    bit sat;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: block mode keeps the running window total and sample count,
  // IIR mode keeps the accumulator; both reset on flush, mode change or reset.
  int win_sum [NCH];
  int win_n   [NCH];
  int m_avg   [NCH];
  int m_acc   [NCH];
  int iir_n   [NCH];
  bit m_set   [NCH];
  bit m_mode = 1'b0;

  function automatic void model_clear();
    for (int i = 0; i < NCH; i++) begin
      win_sum[i] = 0; win_n[i] = 0; m_avg[i] = 0;
      m_acc[i] = 0; iir_n[i] = 0; m_set[i] = 1'b0;
    end
  endfunction

  function automatic void model_sample(input int ch, input int d);
    exp_t e;
    int diff;
    int est;
    e.ch = ch;
    e.settled = m_set[ch];
    e.cyc = cyc;
    if (m_mode == 1'b0) begin
      diff = d - m_avg[ch];
      win_sum[ch] += d;
      win_n[ch]++;
      if (win_n[ch] == WIN) begin
        m_avg[ch] = win_sum[ch] / WIN;
        win_sum[ch] = 0;
        win_n[ch] = 0;
        m_set[ch] = 1'b1;
      end
    end else begin
      est = m_acc[ch] / (1 << IIR_SHIFT);
      diff = d - est;
      m_acc[ch] += d - est;
      iir_n[ch]++;
      if (iir_n[ch] >= WIN) m_set[ch] = 1'b1;
    end
    e.sat = 1'b0;
`ifdef DCR_SAT_EN
    if (diff > (1 << (DW-1)) - 1) begin diff = (1 << (DW-1)) - 1; e.sat = 1'b1; end
    else if (diff < -(1 << (DW-1))) begin diff = -(1 << (DW-1)); e.sat = 1'b1; end
`endif
    e.data = diff;
    sb.push_back(e);
  endfunction

  task automatic issue(input bit v, input int ch, input int d, input bit fl, input bit md);
    @(negedge adc_clk);
    in_valid = v;
    in_ch    = 2'(ch);
    in_data  = DW'(d);
    flush    = fl;
    mode     = md;
    if (fl || (md != m_mode)) model_clear();
    else if (v) model_sample(ch, d);
    m_mode = md;
  endtask

  task automatic idle(input int n);
    repeat (n) issue(1'b0, 0, 0, 1'b0, m_mode);
  endtask

  // Optionally presents one more sample in the same cycle rst rises, so two
  // samples are in flight when the reset lands.
  task automatic do_reset(input int n, input bit with_sample, input int d);
    @(negedge adc_clk);
    rst      = 1'b1;
    in_valid = with_sample;
    in_ch    = 2'd0;
    in_data  = DW'(d);
    flush    = 1'b0;
    sb.delete();
    model_clear();
    m_mode = mode;
    repeat (n) begin
      @(negedge adc_clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== '0 ||
          out_settled !== 1'b0 || out_sat !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%0b ch=%0d data=%0d settled=%0b sat=%0b, need all 0",
                 out_valid, out_ch, out_data, out_settled, out_sat);
      end
    end
    rst = 1'b0;
  endtask

  always @(negedge adc_clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got ch=%0d data=%0d with nothing expected",
                 out_ch, $signed(out_data));
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(out_ch) != e.ch || int'($signed(out_data)) != e.data ||
            out_settled !== e.settled || out_sat !== e.sat || cyc != e.cyc + 2) begin
          errors++;
          $display("FAIL output: got ch=%0d data=%0d settled=%0b sat=%0b lat=%0d, need ch=%0d data=%0d settled=%0b sat=%0b lat=2",
                   out_ch, $signed(out_data), out_settled, out_sat, cyc - e.cyc,
                   e.ch, e.data, e.settled, e.sat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset(3, 1'b0, 0);

    // Block average, constant level on one channel across a full window and one more.
    for (int i = 0; i < 17; i++) issue(1'b1, 0, 1000, 1'b0, 1'b0);
    idle(3);

    // Interleaved channels with a fresh estimate state.
    issue(1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) issue(1'b1, i % 2, (i % 2 == 0) ? 1000 : 3000, 1'b0, 1'b0);
    issue(1'b1, 2, 55, 1'b0, 1'b0);
    issue(1'b1, 3, 77, 1'b0, 1'b0);
    idle(3);

    // IIR step response on ch2 (mode switch acts as a flush).
    issue(1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 2, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) issue(1'b1, 2, 1600, 1'b0, 1'b1);
    idle(3);

    // Flush coinciding with a sample drops it and clears the estimate.
    issue(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) issue(1'b1, 0, 2000, 1'b0, 1'b0);
    issue(1'b1, 0, 2000, 1'b1, 1'b0);
    issue(1'b1, 0, 2000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) issue(1'b1, 0, 2000, 1'b0, 1'b0);
    issue(1'b1, 0, 2000, 1'b0, 1'b1);
    issue(1'b1, 0, 2000, 1'b0, 1'b1);
    idle(3);

    // Large positive and negative differences.
    issue(1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) issue(1'b1, 3, 0, 1'b0, 1'b0);
    issue(1'b1, 3, 4095, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) issue(1'b1, 1, 4095, 1'b0, 1'b0);
    issue(1'b1, 1, 0, 1'b0, 1'b0);
    idle(3);

    // Reset with two samples in flight, then a clean restart.
    idle(2);
    issue(1'b1, 0, 321, 1'b0, 1'b0);
    do_reset(3, 1'b1, 654);
    issue(1'b1, 0, 500, 1'b0, 1'b0);
    idle(3);

    // Randomized traffic with occasional flushes and mode toggles.
    for (int i = 0; i < 500; i++) begin
      bit v;
      bit fl;
      bit md;
      int d;
      int ch;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 59) == 0);
      md = ($urandom_range(0, 79) == 0) ? ~m_mode : m_mode;
      ch = $urandom_range(0, NCH - 1);
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095)
                                       : 1000 * ch + $urandom_range(0, 200);
      issue(v, ch, d, fl, md);
    end
    idle(6);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs still outstanding, need 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
